deser_share_ctrl: RTL and testbench
===================================

Name: deser_share_ctrl

Overview:
- Round-robin controller that shares one deserializer (DATA_BUS_WIDTH-bit parallel output) between N_REQ serial requesters.
- Grants the deserializer to one requester for exactly one word and steers that requester's bit stream onto the shared serial input.
- Returns the finished word tagged with the source id.
- Aborts and resets the deserializer on requester drop-out or a deserializer timeout.

Parameters:
- N_REQ, 4, number of serial requesters (2..16).
- DATA_BUS_WIDTH, 16, bits per word; must match the shared deserializer.
- TIMEOUT, 8, maximum cycles in WAIT_OUT before abort (>=2).

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  reset, asynchronous, active-high.
- req_i  in  N_REQ  per-requester request; held for the whole word.
- data_i  in  N_REQ  per-requester serial bit.
- data_val_i  in  N_REQ  per-requester bit valid.
- grant_o  out  N_REQ  one-hot grant.
- ser_data_o  out  1  serial bit to deserializer data_i.
- ser_data_val_o  out  1  serial valid to deserializer data_val_i.
- deser_srst_o  out  1  reset pulse to deserializer (abort flush).
- deser_data_i  in  DATA_BUS_WIDTH  parallel word from deserializer.
- deser_data_val_i  in  1  word valid from deserializer.
- out_data_o  out  DATA_BUS_WIDTH  delivered word.
- out_id_o  out  $clog2(N_REQ)  source requester of out_data_o.
- out_val_o  out  1  one-cycle valid for out_data_o / out_id_o.
- err_o  out  1  one-cycle abort indication; out_id_o carries the aborted owner.

Behaviour:
- Reset (asynchronous, active-high):
  - grant_o, ser_data_val_o, ser_data_o, out_val_o, err_o = 0; deser_srst_o = 0.
  - out_data_o, out_id_o = 0; state = IDLE; rr pointer = 0; beat count = 0.
- Reset mid-word drops the grant immediately. The deserializer's own reset is the system's responsibility.
- IDLE:
  - If any req_i is set, the picker selects the first set bit at or after the pointer, wrapping (round-robin).
  - Next cycle: grant_o = one-hot(owner), state = GRANT, beat count = 0.
  - No request: stay in IDLE.
- GRANT:
  - ser_data_o / ser_data_val_o are registered copies of data_i[owner] & grant and data_val_i[owner] & grant. One-cycle latency.
  - Valid beats from non-owners are ignored.
  - Each accepted owner valid beat increments the beat count.
  - When the DATA_BUS_WIDTH-th beat is accepted: grant_o cleared next cycle, state = WAIT_OUT, wait counter = 0.
  - If req_i[owner] = 0 while beat count < DATA_BUS_WIDTH, go to ABORT.
  - If the final beat and a req drop occur in the same cycle, the beat wins: go to WAIT_OUT.
- WAIT_OUT:
  - On deser_data_val_i: register out_data_o = deser_data_i, out_id_o = owner, out_val_o = 1 for one cycle.
  - Pointer = (owner+1) mod N_REQ; state = IDLE.
  - The wait counter increments every cycle. When it reaches TIMEOUT without valid, go to ABORT.
  - deser_data_val_i outside WAIT_OUT is ignored. No out_val_o is produced.
- ABORT (one cycle):
  - deser_srst_o = 1, err_o = 1, out_id_o = owner.
  - Pointer = (owner+1) mod N_REQ; grant_o = 0; state = IDLE.
  - Discards the partial word.
- Fairness: a requester holding req_i continuously waits at most N_REQ-1 completed or aborted words.
- Back-to-back words are allowed. The next grant issues no earlier than the cycle after return to IDLE.
- Beat count width is $clog2(DATA_BUS_WIDTH+1). Wait counter width is $clog2(TIMEOUT+1). No wrap is possible by construction.

Decomposition:
- Package deser_share_pkg:
  - State enum: IDLE, GRANT, WAIT_OUT, ABORT.
  - Localparams ID_W = $clog2(N_REQ), CNT_W, TO_W, as functions of the parameters.
- Sub-module rr_priority_picker (N_REQ): combinational rotating-mask priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: any, id, one-hot.
- The FSM, counters and steering registers live in deser_share_ctrl.

Test Plan:
- Single requester: req_i = 4'b0100, 16 valid beats forming 16'hA5C3, deserializer model responds 1 cycle later -> grant_o = 4'b0100 for exactly 16 beats; out_val_o pulse with out_data_o = 16'hA5C3, out_id_o = 2; pointer = 3.
- All four requesting continuously, 8 words -> out_id_o sequence 0,1,2,3,0,1,2,3; no err_o.
- Gapped valid: owner 1 sends 16 beats with data_val_i low every other cycle; requester 3 toggles data_val_i -> word still completes after the 16th owner beat; requester 3 bits never appear on ser_data_val_o.
- Owner 0 drops req_i after 9 beats -> single-cycle deser_srst_o = 1 and err_o = 1 with out_id_o = 0; next grant goes to requester 1 if requesting; no out_val_o.
- Deserializer model never asserts valid, TIMEOUT = 8 -> ABORT 8 cycles after entering WAIT_OUT; err_o pulse; return to IDLE.
- srst_i asserted asynchronously mid-GRANT (beat 5) -> all outputs 0 immediately, without a clock edge; after release, arbitration restarts from pointer 0.

Source files
------------

// File: rtl/deser_share_pkg.sv
// Shared types and width helpers for the deserializer sharing controller.
package deser_share_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_OUT = 2'd2,
    ABORT    = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int to_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/deser_share_ctrl_picker.sv
// Rotating-mask priority encoder: first set request at or after ptr, wrapping.
module rr_priority_picker
  import deser_share_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  id,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] cand;

  // Requests at or above the pointer win; otherwise fall back to the wrapped set.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = (i >= int'(ptr)) && req[i];
    end
    cand   = (|upper) ? upper : req;
    any    = |req;
    id     = '0;
    onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        id        = ID_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deser_share_ctrl.sv
// Round-robin sharing of one serial-to-parallel deserializer between N_REQ
// serial requesters, one word per grant, with abort on drop-out or timeout.
module deser_share_ctrl
  import deser_share_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int TIMEOUT        = 8,
  localparam int ID_W          = id_width(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          data_i,
  input  logic [N_REQ-1:0]          data_val_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      deser_srst_o,
  input  logic [DATA_BUS_WIDTH-1:0] deser_data_i,
  input  logic                      deser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] out_data_o,
  output logic [ID_W-1:0]           out_id_o,
  output logic                      out_val_o,
  output logic                      err_o
);

  localparam int CNT_W = cnt_width(DATA_BUS_WIDTH);
  localparam int TO_W  = to_width(TIMEOUT);

  state_t           state;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] beat;
  logic [TO_W-1:0]  wait_cnt;

  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic [N_REQ-1:0] pick_onehot;

  logic             owner_beat;
  logic             owner_bit;
  logic             owner_req;
  logic [ID_W-1:0]  owner_next;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req    (req_i),
    .ptr    (ptr),
    .any    (pick_any),
    .id     (pick_id),
    .onehot (pick_onehot)
  );

  assign owner_beat = data_val_i[owner];
  assign owner_bit  = data_i[owner];
  assign owner_req  = req_i[owner];
  assign owner_next = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Pulse outputs default low each cycle; abort flags are raised on entry to
  // ABORT so they are visible for exactly the one ABORT cycle.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state          <= IDLE;
      owner          <= '0;
      ptr            <= '0;
      beat           <= '0;
      wait_cnt       <= '0;
      grant_o        <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      deser_srst_o   <= 1'b0;
      out_data_o     <= '0;
      out_id_o       <= '0;
      out_val_o      <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      out_val_o      <= 1'b0;
      err_o          <= 1'b0;
      deser_srst_o   <= 1'b0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_any) begin
            owner   <= pick_id;
            grant_o <= pick_onehot;
            beat    <= '0;
            state   <= GRANT;
          end
        end

        GRANT: begin
          ser_data_o     <= owner_bit;
          ser_data_val_o <= owner_beat;
          // The final beat takes priority over a simultaneous request drop.
          if (owner_beat && (beat == CNT_W'(DATA_BUS_WIDTH - 1))) begin
            grant_o  <= '0;
            wait_cnt <= '0;
            state    <= WAIT_OUT;
          end else begin
            if (owner_beat) begin
              beat <= beat + 1'b1;
            end
            if (!owner_req) begin
              grant_o      <= '0;
              deser_srst_o <= 1'b1;
              err_o        <= 1'b1;
              out_id_o     <= owner;
              ptr          <= owner_next;
              state        <= ABORT;
            end
          end
        end

        WAIT_OUT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (deser_data_val_i) begin
            out_data_o <= deser_data_i;
            out_id_o   <= owner;
            out_val_o  <= 1'b1;
            ptr        <= owner_next;
            state      <= IDLE;
          end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
            deser_srst_o <= 1'b1;
            err_o        <= 1'b1;
            out_id_o     <= owner;
            ptr          <= owner_next;
            state        <= ABORT;
          end
        end

        ABORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deser_share_ctrl.sv
// Self-checking bench for deser_share_ctrl: vector table, hand sequences and
// randomized round-robin traffic against a transaction-level model.
module tb_deser_share_ctrl;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic           clk_i = 1'b0;
  logic           srst_i;
  logic [N-1:0]   req_i;
  logic [N-1:0]   data_i;
  logic [N-1:0]   data_val_i;
  logic [N-1:0]   grant_o;
  logic           ser_data_o;
  logic           ser_data_val_o;
  logic           deser_srst_o;
  logic [W-1:0]   deser_data_i;
  logic           deser_data_val_i;
  logic [W-1:0]   out_data_o;
  logic [IDW-1:0] out_id_o;
  logic           out_val_o;
  logic           err_o;

  always #5 clk_i = ~clk_i;

  deser_share_ctrl #(
    .N_REQ          (N),
    .DATA_BUS_WIDTH (W),
    .TIMEOUT        (TO)
  ) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .req_i            (req_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .grant_o          (grant_o),
    .ser_data_o       (ser_data_o),
    .ser_data_val_o   (ser_data_val_o),
    .deser_srst_o     (deser_srst_o),
    .deser_data_i     (deser_data_i),
    .deser_data_val_i (deser_data_val_i),
    .out_data_o       (out_data_o),
    .out_id_o         (out_id_o),
    .out_val_o        (out_val_o),
    .err_o            (err_o)
  );

  typedef struct {
    logic         is_err;
    int           id;
    logic [W-1:0] data;
    int           cyc;
  } event_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] word;
    bit           gap;
    int           lat;
    int           drop;
    bit           exp_err;
    int           exp_id;
  } vec_t;

  event_t       ev_q[$];
  vec_t         tbl[8];

  int           check_count = 0;
  int           fail_count  = 0;
  int           cycle       = 0;
  int           ptr_model   = 0;

  logic [N-1:0] req_en;
  logic [N-1:0] prev_grant;
  logic [W-1:0] word[N];
  logic [W-1:0] last_word[N];
  int           sent[N];
  bit           gap_mode, oneshot, draining, rand_lat, stray;
  int           drop_after;

  logic [W-1:0] shreg;
  int           shcnt, cd, cur_lat, word_done_cyc;
  bit           pend;
  logic         exp_ser_val, exp_ser_data;

  task automatic checkOutput(input string name, input int act, input int exp);
    check_count++;
    if (act != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int next_owner(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic applyStimulus();
    logic dv, db;
    @(negedge clk_i);
    cycle++;
    checkOutput("ser_val", int'(ser_data_val_o), int'(exp_ser_val));
    checkOutput("ser_data", int'(ser_data_o), int'(exp_ser_data));
    checkOutput("grant_onehot", int'($onehot0(grant_o)), 1);
    if (out_val_o || err_o) ev_q.push_back('{err_o, int'(out_id_o), out_data_o, cycle});
    if (err_o || deser_srst_o) checkOutput("srst_with_err", int'(deser_srst_o), int'(err_o));
    if (ser_data_val_o) begin
      shreg = {shreg[W-2:0], ser_data_o};
      shcnt++;
      if (shcnt == W) begin
        shcnt = 0;
        word_done_cyc = cycle;
        if (cur_lat > 0) begin
          pend = 1'b1;
          cd   = cur_lat;
        end
      end
    end
    if (deser_srst_o) begin
      shcnt = 0;
      pend  = 1'b0;
    end
    deser_data_val_i = 1'b0;
    deser_data_i     = W'($urandom);
    if (pend) begin
      cd--;
      if (cd == 0) begin
        pend             = 1'b0;
        deser_data_val_i = 1'b1;
        deser_data_i     = shreg;
      end
    end
    if (stray) begin
      deser_data_val_i = 1'b1;
      stray            = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (prev_grant[i] && !grant_o[i]) begin
        last_word[i] = word[i];
        word[i]      = W'($urandom);
        sent[i]      = 0;
        if (oneshot) req_en[i] = 1'b0;
      end
      if (grant_o[i] && !prev_grant[i] && rand_lat) cur_lat = $urandom_range(1, TO);
      if (draining && !grant_o[i]) req_en[i] = 1'b0;
      if (oneshot && (|grant_o) && !grant_o[i]) req_en[i] = 1'b0;
      dv = 1'($urandom);
      db = 1'($urandom);
      if (grant_o[i] && sent[i] < W) begin
        if (drop_after >= 0 && sent[i] == drop_after) begin
          req_en[i] = 1'b0;
          dv        = 1'b0;
        end else begin
          dv = gap_mode ? 1'($urandom) : 1'b1;
          if (dv) begin
            db = word[i][W-1-sent[i]];
            sent[i]++;
          end
        end
      end
      data_val_i[i] = dv;
      data_i[i]     = db;
      req_i[i]      = req_en[i];
    end
    prev_grant   = grant_o;
    exp_ser_val  = |(grant_o & data_val_i);
    exp_ser_data = |(grant_o & data_i);
  endtask

  task automatic clearModel();
    req_en = '0; prev_grant = '0; req_i = '0; data_i = '0; data_val_i = '0;
    deser_data_i = '0; deser_data_val_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      word[i] = '0;
      last_word[i] = '0;
    end
    shreg = '0; shcnt = 0; pend = 1'b0; cd = 0;
    exp_ser_val = 1'b0; exp_ser_data = 1'b0;
    ev_q.delete();
    ptr_model = 0;
  endtask

  task automatic runEvents(input int n, input int budget, input string name);
    int k = 0;
    while (ev_q.size() < n && k < budget) begin
      applyStimulus();
      k++;
    end
    if (ev_q.size() < n) checkOutput({name, "_timeout"}, ev_q.size(), n);
  endtask

  task automatic checkEvent(input string name, input bit exp_err, input int exp_id,
                            input logic [W-1:0] exp_data, input int exp_lat);
    event_t ev;
    if (ev_q.size() == 0) begin
      checkOutput({name, "_present"}, 0, 1);
      return;
    end
    ev = ev_q.pop_front();
    checkOutput({name, "_err"}, int'(ev.is_err), int'(exp_err));
    checkOutput({name, "_id"}, ev.id, exp_id);
    if (!exp_err) checkOutput({name, "_data"}, int'(ev.data), int'(exp_data));
    if (exp_lat > 0) checkOutput({name, "_latency"}, ev.cyc - word_done_cyc, exp_lat);
  endtask

  task automatic modelCheck(input logic [N-1:0] mask);
    int exp_id;
    exp_id = next_owner(mask, ptr_model);
    checkEvent("rr_word", 1'b0, exp_id, last_word[exp_id], cur_lat);
    ptr_model = (exp_id + 1) % N;
  endtask

  // Continuous requesters in mask; each event must follow round-robin order.
  task automatic runModel(input logic [N-1:0] mask, input int words, input int budget);
    int got = 0;
    int k = 0;
    oneshot = 1'b0; draining = 1'b0; rand_lat = 1'b1; drop_after = -1;
    req_en = mask;
    while (got < words && k < budget) begin
      applyStimulus();
      k++;
      if (ev_q.size() > 0) begin
        modelCheck(mask);
        got++;
      end
    end
    checkOutput("rr_words_done", got, words);
    draining = 1'b1;
    for (int c = 0; c < 250; c++) begin
      applyStimulus();
      if (ev_q.size() > 0) modelCheck(mask);
    end
    draining = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    gap_mode = 1'b0; oneshot = 1'b0; draining = 1'b0; rand_lat = 1'b0; stray = 1'b0;
    drop_after = -1; cur_lat = 0; word_done_cyc = 0;
    srst_i = 1'b1;
    clearModel();
    @(negedge clk_i);
    @(negedge clk_i);
    srst_i = 1'b0;

    checkOutput("rst_grant", int'(grant_o), 0);
    checkOutput("rst_ser_val", int'(ser_data_val_o), 0);
    checkOutput("rst_ser_data", int'(ser_data_o), 0);
    checkOutput("rst_out_val", int'(out_val_o), 0);
    checkOutput("rst_err", int'(err_o), 0);
    checkOutput("rst_deser_srst", int'(deser_srst_o), 0);
    checkOutput("rst_out_data", int'(out_data_o), 0);
    checkOutput("rst_out_id", int'(out_id_o), 0);

    tbl[0] = '{4'b0100, 16'hA5C3, 1'b0, 1, -1, 1'b0, 2};
    tbl[1] = '{4'b0101, 16'h1234, 1'b0, 3, -1, 1'b0, 0};
    tbl[2] = '{4'b1001, 16'hFFFF, 1'b0, 8, -1, 1'b0, 3};
    tbl[3] = '{4'b0010, 16'h0001, 1'b0, 0, -1, 1'b1, 1};
    tbl[4] = '{4'b0011, 16'h8000, 1'b0, 2,  9, 1'b1, 0};
    tbl[5] = '{4'b1110, 16'h5A5A, 1'b1, 4, -1, 1'b0, 1};
    tbl[6] = '{4'b1000, 16'h0F0F, 1'b0, 1, -1, 1'b0, 3};
    tbl[7] = '{4'b0001, 16'hC001, 1'b0, 1,  0, 1'b1, 0};

    oneshot = 1'b1;
    for (int e = 0; e < 8; e++) begin
      gap_mode   = tbl[e].gap;
      drop_after = tbl[e].drop;
      cur_lat    = tbl[e].lat;
      for (int i = 0; i < N; i++) word[i] = tbl[e].word;
      req_en = tbl[e].mask;
      runEvents(1, 300, $sformatf("vec%0d", e));
      checkEvent($sformatf("vec%0d", e), tbl[e].exp_err, tbl[e].exp_id, tbl[e].word,
                 (tbl[e].drop >= 0) ? -1 : ((tbl[e].lat == 0) ? TO : tbl[e].lat));
      repeat (4) applyStimulus();
      checkOutput($sformatf("vec%0d_no_extra", e), ev_q.size(), 0);
      ev_q.delete();
      ptr_model = (tbl[e].exp_id + 1) % N;
    end
    drop_after = -1;
    gap_mode   = 1'b0;

    stray = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("stray_deser_valid_ignored", ev_q.size(), 0);

    for (int i = 0; i < N; i++) word[i] = 16'h6B2D;
    cur_lat = 1;
    req_en  = 4'b0100;
    for (int k = 0; k < 100 && sent[2] < 5; k++) applyStimulus();
    #2;
    srst_i = 1'b1;
    #1;
    checkOutput("async_rst_grant", int'(grant_o), 0);
    checkOutput("async_rst_ser_val", int'(ser_data_val_o), 0);
    checkOutput("async_rst_ser_data", int'(ser_data_o), 0);
    checkOutput("async_rst_out_val", int'(out_val_o), 0);
    checkOutput("async_rst_err", int'(err_o), 0);
    checkOutput("async_rst_deser_srst", int'(deser_srst_o), 0);
    checkOutput("async_rst_out_id", int'(out_id_o), 0);
    checkOutput("async_rst_out_data", int'(out_data_o), 0);
    clearModel();
    @(negedge clk_i);
    @(negedge clk_i);
    srst_i = 1'b0;

    gap_mode = 1'b1;
    runModel(4'b1111, 8, 1500);

    for (int r = 0; r < 6; r++) begin
      gap_mode = 1'($urandom);
      runModel(N'($urandom_range(1, (1 << N) - 1)), 4, 800);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
